// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready input and framed serial output.
// Emits first/last markers per bit and a done pulse after each word; optional idle gap between words.
module piso_serializer #(
   parameter int          WIDTH      = 4,
   parameter bit          LSB_FIRST  = 1'b1,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pdata_in,
   input  logic             pdata_valid,
   output logic             pdata_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_first,
   output logic             sout_last,
   output logic             busy,
   output logic             done
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
   localparam logic [3:0]    GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    bitcnt_q, bitcnt_d;
   logic [3:0]       gapcnt_q, gapcnt_d;
   logic             sout_q, sout_d;
   logic             valid_q, valid_d;
   logic             first_q, first_d;
   logic             last_q, last_d;
   logic             done_q, done_d;

   logic             last_bit;
   logic             accept;

   // last_bit is true while the final bit of the current word is on sout
   assign last_bit    = (state_q == SHIFT) && (bitcnt_q == LAST_IDX);
   assign pdata_ready = !reset && ((state_q == IDLE) || (last_bit && (GAP_CYCLES == 0)));
   assign accept      = pdata_valid && pdata_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         gapcnt_q <= '0;
         sout_q   <= 1'b0;
         valid_q  <= 1'b0;
         first_q  <= 1'b0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         gapcnt_q <= gapcnt_d;
         sout_q   <= sout_d;
         valid_q  <= valid_d;
         first_q  <= first_d;
         last_q   <= last_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      gapcnt_d = gapcnt_q;
      sout_d   = 1'b0;
      valid_d  = 1'b0;
      first_d  = 1'b0;
      last_d   = 1'b0;
      done_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            state_d = IDLE;
         end
         SHIFT: begin
            if (last_bit) begin
               done_d = 1'b1;
               if (GAP_CYCLES == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d  = GAP;
                  gapcnt_d = GAP_LAST;
               end
            end else begin
               bitcnt_d = bitcnt_q + 1'b1;
               valid_d  = 1'b1;
               last_d   = (bitcnt_q == (LAST_IDX - 1'b1));
               if (LSB_FIRST) begin
                  shreg_d = shreg_q >> 1;
                  sout_d  = shreg_q[1];
               end else begin
                  shreg_d = shreg_q << 1;
                  sout_d  = shreg_q[WIDTH-2];
               end
            end
         end
         GAP: begin
            if (gapcnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               gapcnt_d = gapcnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Acceptance overrides the case above; it is only possible from IDLE or the
      // gapless last bit, so a back-to-back word reloads without a bubble.
      if (accept) begin
         state_d  = SHIFT;
         shreg_d  = pdata_in;
         bitcnt_d = '0;
         valid_d  = 1'b1;
         first_d  = 1'b1;
         last_d   = 1'b0;
         sout_d   = LSB_FIRST ? pdata_in[0] : pdata_in[WIDTH-1];
      end
   end

   assign sout       = sout_q;
   assign sout_valid = valid_q;
   assign sout_first = first_q;
   assign sout_last  = last_q;
   assign busy       = (state_q != IDLE);
   assign done       = done_q;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out transmitter. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock. With each bit it emits a valid flag plus first-bit and last-bit frame markers, so a downstream serial-in parallel-out receiver can align words without a free-running counter. It sits between a parallel producer and a serial link. Optional idle gap cycles are inserted between words.

Parameters:
WIDTH, 4, word width in bits; legal range WIDTH >= 2.
LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit WIDTH-1 is sent first.
GAP_CYCLES, 0, number of idle cycles (sout_valid=0) forced after each word; legal range 0..15.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
pdata_in  input  WIDTH  parallel word to transmit.
pdata_valid  input  1  producer has a word on pdata_in.
pdata_ready  output  1  serializer can accept a word this cycle.
sout  output  1  serial data bit.
sout_valid  output  1  sout carries a valid bit this cycle.
sout_first  output  1  current bit is the first bit of a word.
sout_last  output  1  current bit is the last bit of a word.
busy  output  1  a word is being shifted or a gap is running.
done  output  1  one-cycle pulse in the cycle after a word's last bit.

Behaviour:
- Reset is synchronous and active-high. On a rising edge with reset=1:
  - state goes to IDLE; shift register and bit counter clear to 0; gap counter clears to 0.
  - sout, sout_valid, sout_first, sout_last, busy and done all become 0.
  - pdata_ready is forced to 0 while reset is high.
- States are IDLE, SHIFT and GAP.
- Acceptance: a word is accepted on a rising edge where pdata_valid=1 and pdata_ready=1.
  - pdata_ready=1 in IDLE.
  - pdata_ready=1 in the SHIFT cycle that presents the last bit, only when GAP_CYCLES=0.
  - pdata_ready=0 at all other times.
- pdata_in is sampled only at acceptance. Later changes to pdata_in are ignored until the next acceptance.
- Latency: the first bit is registered on the acceptance edge. It is visible on sout in the cycle that follows, with sout_valid=1 and sout_first=1.
- Bit k (k = 0..WIDTH-1 in transmit order) appears k+1 cycles after acceptance.
  - Transmit order is LSB-first or MSB-first per LSB_FIRST.
  - sout_last=1 only on bit WIDTH-1.
- Bit counter is ceil(log2(WIDTH)) bits wide. It counts 0..WIDTH-1 and must never wrap mid-word.
- sout_valid is 1 for exactly WIDTH consecutive cycles per word.
- sout is driven to 0 whenever sout_valid=0.
- Transitions out of SHIFT on the last bit:
  - GAP_CYCLES=0 and a word is accepted in that cycle: remain in SHIFT. The new word's first bit follows with no bubble; sout_first=1 in the cycle right after the previous sout_last=1.
  - GAP_CYCLES=0 and no word is accepted: go to IDLE.
  - GAP_CYCLES>0: go to GAP.
- GAP: lasts exactly GAP_CYCLES cycles with sout_valid=0, busy=1, pdata_ready=0, then goes to IDLE.
- busy=1 in SHIFT and GAP, 0 in IDLE.
- done is registered. It pulses 1 for one cycle in the cycle after each sout_last=1, including in back-to-back operation where the next word is already shifting.
- For WIDTH=2, sout_first and sout_last are on consecutive cycles and never both 1.
- Reset mid-word or mid-gap: the partial word is dropped and no done pulse is produced. Outputs follow the reset values from the next edge.
- reset takes priority over simultaneous pdata_valid.

Test Plan:
- Reset: hold reset 2 cycles with pdata_valid=1 -> pdata_ready=0 and all outputs 0; no word is accepted.
- Single word, WIDTH=4, LSB_FIRST=1, pdata_in=4'b0110 -> sout = 0,1,1,0 on cycles 1-4 after acceptance; sout_first on cycle 1, sout_last on cycle 4, done on cycle 5, busy=0 on cycle 5.
- LSB_FIRST=0, pdata_in=4'b0110 -> sout = 0,1,1,0 (MSB first); repeat with 4'b1101 -> sout = 1,1,0,1.
- Back-to-back, GAP_CYCLES=0: words 4'h6 then 4'h9, pdata_valid held high -> 8 contiguous sout_valid cycles carrying 0,1,1,0,1,0,0,1; pdata_ready=1 during the first word's last bit; done pulses twice.
- GAP_CYCLES=2: two words -> exactly 2 cycles with sout_valid=0 and pdata_ready=0 between them; busy=1 throughout.
- Hold-off: change pdata_in to 4'hF while busy -> transmitted bits unchanged; pdata_ready=0. Also assert reset during bit 2 -> sout_valid=0 on the next cycle, no done pulse, then a new word of 4'h3 transmits correctly.
